sc_stream_to_binary_collector: RTL and testbench
================================================

// Module: sc_stream_to_binary_collector
// PURPOSE
//   Stochastic-to-digital back end of the SC matrix multiply datapath. Counts
//   the ones on NUM_STREAMS parallel stochastic bitstreams over a fixed window.
//   Then drains the counts, one element per beat, as binary values with a write
//   address and a valid/ready handshake into the output matrix buffer.
// PARAMETERS
//   NUM_STREAMS       16  streams = BATCH_SIZE*OUTPUT_FEATURES, row-major (m*O+o)
//   BINARY_PRECISION  8   result width P; window = 2**P valid beats
//   ADDR_WIDTH        4   out_addr width, >= clog2(NUM_STREAMS)
// PORTS
//   clk           in   1            clock, all state on rising edge
//   rst           in   1            asynchronous, active-low reset
//   start         in   1            pulse: clear counters, begin a window
//   stream_in     in   NUM_STREAMS  one stochastic bit per stream per beat
//   stream_valid  in   1            stream_in valid this cycle
//   busy          out  1            high from start accept until done
//   out_data      out  P            binary count for element out_addr
//   out_addr      out  ADDR_WIDTH   element index 0..NUM_STREAMS-1
//   out_valid     out  1            out_data/out_addr valid (write enable)
//   out_ready     in   1            sink accepts current element
//   done          out  1            one-cycle pulse after last element accepted
// BEHAVIOUR
//   - Reset (rst low, async): state IDLE, all counters 0, beat counter 0.
//     busy=0, out_valid=0, done=0, out_data=0, out_addr=0. Reset mid-window or
//     mid-drain aborts the job; no element is emitted after release.
//   - FSM IDLE -> COUNT -> DRAIN -> DONE -> IDLE.
//   - IDLE: start=1 clears every stream counter and the beat counter.
//     busy=1 from the next cycle. stream_in on the start cycle is not counted.
//   - COUNT: on each cycle with stream_valid=1, counter[i] += stream_in[i] for
//     all i, and the beat counter increments. stream_valid=0 stalls; nothing
//     changes. After beat 2**P is counted, go to DRAIN.
//   - Counter width P+1 internally. The emitted value saturates to 2**P-1 when
//     the count is 2**P, i.e. all ones.
//   - DRAIN: out_valid=1 starting the cycle after the last beat, out_addr=0.
//     out_data/out_addr registered and held stable while out_valid&&!out_ready.
//     On out_valid&&out_ready, advance to addr+1 next cycle with no bubble.
//     After addr NUM_STREAMS-1 is accepted, out_valid=0 and go to DONE.
//   - DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
//     A start in the DONE cycle is ignored.
//   - start while busy (COUNT/DRAIN/DONE) is ignored; no restart.
//   - stream_valid outside COUNT is ignored.
//   - out_ready is don't-care when out_valid=0.
//   - Latency: last valid beat at cycle t -> first element valid at t+1.
//     Minimum job length = 1 + 2**P + NUM_STREAMS + 1 cycles.
// TESTING  (P=4 -> window 16, NUM_STREAMS=4)
//   1. rst low for 3 cycles mid-COUNT, then release -> busy=0, out_valid=0,
//      done=0; next start gives a fresh job with counts from 0.
//   2. start, then 16 valid beats with stream_in=4'b0101 and out_ready=1 ->
//      addr0..3 give data 15,0,15,0 (sat), one per cycle; done 1 cycle later.
//   3. Stream0 set on 8 of 16 beats, stream1 on 3, stream2 on 16, stream3
//      never -> data 8,3,15,0.
//   4. stream_valid toggled 1/0 for 32 cycles -> counting ends after the
//      16th valid beat only; out_valid rises the next cycle.
//   5. out_ready low 5 cycles at addr1 -> addr1/data held stable 5 cycles,
//      then addr2 on the cycle after ready rises; 4 total handshakes.
//   6. start pulsed during COUNT and during DRAIN -> no effect on counts or
//      addr sequence; start on the start-accept cycle with stream_in=4'hF
//      -> that sample not counted.

Source files
------------

// File: rtl/sc_stream_to_binary_collector.sv
// Counts ones on NUM_STREAMS stochastic bitstreams over 2**P valid beats, then drains saturated counts one element per beat.
// Latency: last valid beat at cycle t -> element 0 valid at t+1; one element per accepted handshake, no bubbles.
// Backpressure: out_valid/out_data/out_addr held stable while out_ready is low; stream_valid=0 stalls counting.
module sc_stream_to_binary_collector #(
    parameter int NUM_STREAMS      = 16,
    parameter int BINARY_PRECISION = 8,
    parameter int ADDR_WIDTH       = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [NUM_STREAMS-1:0]      stream_in,
    input  logic                        stream_valid,
    output logic                        busy,
    output logic [BINARY_PRECISION-1:0] out_data,
    output logic [ADDR_WIDTH-1:0]       out_addr,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        done
);
    localparam int P  = BINARY_PRECISION;
    localparam int AW = ADDR_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_COUNT, S_DRAIN, S_FIN} state_t;

    state_t       state;
    logic [P:0]   cnt [NUM_STREAMS];
    logic [P-1:0] beat_cnt;
    logic [P:0]   nxt_sel;

    // A full window of ones reads 2**P, which does not fit in P bits.
    function automatic logic [P-1:0] sat(input logic [P:0] c);
        return c[P] ? {P{1'b1}} : c[P-1:0];
    endfunction

    always_comb begin
        nxt_sel = '0;
        for (int i = 0; i < NUM_STREAMS; i++) begin
            if (i == int'(out_addr) + 1) nxt_sel = cnt[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            beat_cnt  <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
            for (int i = 0; i < NUM_STREAMS; i++) cnt[i] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        for (int i = 0; i < NUM_STREAMS; i++) cnt[i] <= '0;
                        beat_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= S_COUNT;
                    end
                end
                S_COUNT: begin
                    if (stream_valid) begin
                        for (int i = 0; i < NUM_STREAMS; i++)
                            cnt[i] <= cnt[i] + (P+1)'(stream_in[i]);
                        beat_cnt <= beat_cnt + P'(1);
                        // Element 0 is loaded from the in-flight final beat so it is valid next cycle.
                        if (&beat_cnt) begin
                            state     <= S_DRAIN;
                            out_valid <= 1'b1;
                            out_addr  <= '0;
                            out_data  <= sat(cnt[0] + (P+1)'(stream_in[0]));
                        end
                    end
                end
                S_DRAIN: begin
                    if (out_ready) begin
                        if (int'(out_addr) == NUM_STREAMS - 1) begin
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= S_FIN;
                        end else begin
                            out_addr <= out_addr + AW'(1);
                            out_data <= sat(nxt_sel);
                        end
                    end
                end
                S_FIN:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sc_stream_to_binary_collector.sv
// Bench for sc_stream_to_binary_collector at P=4 (window 16) and 4 streams.
// Expected counts come from per-stream tallies of the beats the bench drives.
module tb_sc_stream_to_binary_collector;
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] stream_in;
    logic       stream_valid;
    logic       busy;
    logic [3:0] out_data;
    logic [1:0] out_addr;
    logic       out_valid;
    logic       out_ready;
    logic       done;

    sc_stream_to_binary_collector #(
        .NUM_STREAMS(4), .BINARY_PRECISION(4), .ADDR_WIDTH(2)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stream_in(stream_in),
        .stream_valid(stream_valid), .busy(busy), .out_data(out_data),
        .out_addr(out_addr), .out_valid(out_valid), .out_ready(out_ready),
        .done(done)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    logic [3:0] stim [16];
    int exp_d [4];
    int tr_v[$], tr_a[$], tr_d[$], tr_r[$];
    int busy_after_start, lat_ok, early_valid;
    int done_v, done_busy, done_ov, done_after, busy_after;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one job: start (with stream_in=F on the accept cycle), 16 valid beats, then the drain.
    task automatic run_job(input int vmode, input int rmode, input bit poke);
        int beats, cyc, hs, stall_ct;
        bit v, r;
        for (int k = 0; k < 4; k++) exp_d[k] = 0;
        tr_v.delete(); tr_a.delete(); tr_d.delete(); tr_r.delete();
        early_valid = 0;
        start = 1'b1; stream_in = 4'hF; stream_valid = 1'b1; out_ready = 1'($urandom);
        tick();
        start = 1'b0;
        busy_after_start = int'(busy);
        beats = 0; cyc = 0;
        while (beats < 16 && cyc < 400) begin
            case (vmode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            stream_valid = v;
            stream_in = v ? stim[beats] : 4'($urandom);
            if (v) begin
                for (int k = 0; k < 4; k++) if (stim[beats][k]) exp_d[k]++;
                beats++;
            end
            start = poke ? 1'($urandom) : 1'b0;
            out_ready = 1'($urandom);
            if (out_valid === 1'b1) early_valid++;
            tick();
            cyc++;
        end
        for (int k = 0; k < 4; k++) if (exp_d[k] > 15) exp_d[k] = 15;
        lat_ok = int'(out_valid === 1'b1);
        hs = 0; cyc = 0; stall_ct = 0;
        while (hs < 4 && cyc < 200) begin
            case (rmode)
                0: r = 1'b1;
                1: begin
                    r = !(out_valid === 1'b1 && out_addr == 2'd1 && stall_ct < 5);
                    if (!r) stall_ct++;
                end
                default: r = 1'($urandom);
            endcase
            out_ready = r;
            stream_valid = 1'($urandom);
            stream_in = 4'($urandom);
            start = poke ? 1'($urandom) : 1'b0;
            tr_v.push_back(int'(out_valid === 1'b1));
            tr_a.push_back(int'(out_addr));
            tr_d.push_back(int'(out_data));
            tr_r.push_back(int'(r));
            if (out_valid === 1'b1 && r) hs++;
            tick();
            cyc++;
        end
        stream_valid = 1'b0; out_ready = 1'b0;
        start = poke;
        done_v = int'(done); done_busy = int'(busy); done_ov = int'(out_valid);
        tick();
        start = 1'b0;
        done_after = int'(done);
        tick();
        busy_after = int'(busy);
    endtask

    task automatic test_reset();
        n_chk += 5;
        if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        if (done !== 1'b0)      begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        if (out_data !== 4'd0)  begin n_fail++; $display("FAIL reset_out_data: got %0d want 0", out_data); end
        if (out_addr !== 2'd0)  begin n_fail++; $display("FAIL reset_out_addr: got %0d want 0", out_addr); end
    endtask

    task automatic test_midjob_reset();
        int seen;
        start = 1'b1; stream_in = 4'hF; stream_valid = 1'b0;
        tick();
        start = 1'b0; stream_valid = 1'b1;
        repeat (6) tick();
        #2 rst = 1'b0;
        #1;
        n_chk += 2;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL async_reset_busy: got %b want 0", busy); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL async_reset_done: got %b want 0", done); end
        repeat (3) tick();
        rst = 1'b1;
        seen = 0;
        for (int c = 0; c < 24; c++) begin
            stream_in = 4'($urandom);
            if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) seen++;
            tick();
        end
        stream_valid = 1'b0;
        n_chk++;
        if (seen != 0) begin n_fail++; $display("FAIL post_reset_idle: active cycles %0d want 0", seen); end
        for (int b = 0; b < 16; b++) stim[b] = {1'b0, 1'b1, b < 3, b % 2 == 0};
        run_job(0, 0, 1'b0);
        begin
            int want [4] = '{8, 3, 15, 0};
            int k = 0;
            for (int j = 0; j < tr_v.size(); j++) if (tr_v[j] != 0 && tr_r[j] != 0) begin
                n_chk++;
                if (k > 3 || tr_a[j] != k || tr_d[j] != want[k]) begin
                    n_fail++; $display("FAIL fresh_job_elem%0d: got addr %0d data %0d", k, tr_a[j], tr_d[j]);
                end
                k++;
            end
        end
    endtask

    task automatic test_saturate_pattern();
        int want [4] = '{15, 0, 15, 0};
        for (int b = 0; b < 16; b++) stim[b] = 4'b0101;
        run_job(0, 0, 1'b0);
        n_chk += 4;
        if (busy_after_start != 1) begin n_fail++; $display("FAIL busy_after_start: got %0d want 1", busy_after_start); end
        if (lat_ok != 1)  begin n_fail++; $display("FAIL first_elem_latency: out_valid %0d want 1", lat_ok); end
        if (tr_v.size() != 4) begin n_fail++; $display("FAIL drain_cycles: got %0d want 4", tr_v.size()); end
        if (early_valid != 0) begin n_fail++; $display("FAIL early_valid: got %0d want 0", early_valid); end
        for (int j = 0; j < tr_v.size() && j < 4; j++) begin
            n_chk++;
            if (tr_v[j] != 1 || tr_a[j] != j || tr_d[j] != want[j]) begin
                n_fail++; $display("FAIL sat_elem%0d: got v%0d addr %0d data %0d want data %0d", j, tr_v[j], tr_a[j], tr_d[j], want[j]);
            end
        end
        n_chk += 4;
        if (done_v != 1)     begin n_fail++; $display("FAIL done_pulse: got %0d want 1", done_v); end
        if (done_busy != 0)  begin n_fail++; $display("FAIL done_busy: got %0d want 0", done_busy); end
        if (done_ov != 0)    begin n_fail++; $display("FAIL done_out_valid: got %0d want 0", done_ov); end
        if (done_after != 0) begin n_fail++; $display("FAIL done_width: got %0d want 0", done_after); end
    endtask

    task automatic test_stall_valid();
        int k = 0;
        for (int b = 0; b < 16; b++) stim[b] = 4'($urandom);
        run_job(1, 0, 1'b0);
        n_chk += 2;
        if (early_valid != 0) begin n_fail++; $display("FAIL toggle_early_valid: got %0d want 0", early_valid); end
        if (lat_ok != 1)      begin n_fail++; $display("FAIL toggle_latency: out_valid %0d want 1", lat_ok); end
        for (int j = 0; j < tr_v.size(); j++) if (tr_v[j] != 0 && tr_r[j] != 0) begin
            n_chk++;
            if (k > 3 || tr_a[j] != k || tr_d[j] != exp_d[k]) begin
                n_fail++; $display("FAIL toggle_elem%0d: got addr %0d data %0d want %0d", k, tr_a[j], tr_d[j], (k < 4) ? exp_d[k] : -1);
            end
            k++;
        end
    endtask

    task automatic test_backpressure();
        int n_at1 = 0, d1 = -1, bad = 0, hs = 0, last1 = -1;
        for (int b = 0; b < 16; b++) stim[b] = 4'($urandom);
        run_job(0, 1, 1'b0);
        for (int j = 0; j < tr_v.size(); j++) begin
            if (tr_v[j] != 0 && tr_a[j] == 1) begin
                n_at1++; last1 = j;
                if (d1 < 0) d1 = tr_d[j]; else if (tr_d[j] != d1) bad++;
            end
            if (tr_v[j] != 0 && tr_r[j] != 0) hs++;
        end
        n_chk += 5;
        if (n_at1 != 6) begin n_fail++; $display("FAIL hold_cycles_addr1: got %0d want 6", n_at1); end
        if (bad != 0)   begin n_fail++; $display("FAIL hold_data_stable: changes %0d want 0", bad); end
        if (d1 != exp_d[1]) begin n_fail++; $display("FAIL hold_data_value: got %0d want %0d", d1, exp_d[1]); end
        if (hs != 4)    begin n_fail++; $display("FAIL handshakes: got %0d want 4", hs); end
        if (last1 < 0 || last1 + 1 >= tr_v.size() || tr_v[last1+1] != 1 || tr_a[last1+1] != 2) begin
            n_fail++; $display("FAIL addr2_after_ready: idx %0d size %0d", last1, tr_v.size());
        end
    endtask

    task automatic test_start_ignored();
        int want [4] = '{8, 3, 15, 0};
        int k = 0;
        for (int b = 0; b < 16; b++) stim[b] = {1'b0, 1'b1, b < 3, b % 2 == 0};
        run_job(0, 0, 1'b1);
        for (int j = 0; j < tr_v.size(); j++) if (tr_v[j] != 0 && tr_r[j] != 0) begin
            n_chk++;
            if (k > 3 || tr_a[j] != k || tr_d[j] != want[k]) begin
                n_fail++; $display("FAIL poke_elem%0d: got addr %0d data %0d", k, tr_a[j], tr_d[j]);
            end
            k++;
        end
        n_chk += 2;
        if (k != 4) begin n_fail++; $display("FAIL poke_handshakes: got %0d want 4", k); end
        if (busy_after != 0) begin n_fail++; $display("FAIL start_in_done: busy %0d want 0", busy_after); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            int k = 0, unstable = 0;
            for (int b = 0; b < 16; b++) stim[b] = 4'($urandom);
            run_job(2, 2, 1'b1);
            for (int j = 0; j < tr_v.size(); j++) begin
                if (tr_v[j] != 0 && tr_r[j] != 0) begin
                    n_chk++;
                    if (k > 3 || tr_a[j] != k || tr_d[j] != exp_d[k]) begin
                        n_fail++; $display("FAIL rand%0d_elem%0d: got addr %0d data %0d", it, k, tr_a[j], tr_d[j]);
                    end
                    k++;
                end else if (tr_v[j] != 0 && j + 1 < tr_v.size()) begin
                    if (tr_v[j+1] != 1 || tr_a[j+1] != tr_a[j] || tr_d[j+1] != tr_d[j]) unstable++;
                end
            end
            n_chk += 3;
            if (k != 4)        begin n_fail++; $display("FAIL rand%0d_handshakes: got %0d want 4", it, k); end
            if (unstable != 0) begin n_fail++; $display("FAIL rand%0d_stall_hold: got %0d want 0", it, unstable); end
            if (done_v != 1)   begin n_fail++; $display("FAIL rand%0d_done: got %0d want 1", it, done_v); end
            repeat ($urandom_range(0, 3)) tick();
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; stream_in = '0; stream_valid = 1'b0; out_ready = 1'b0;
        repeat (3) tick();
        test_reset();
        rst = 1'b1;
        tick();
        test_midjob_reset();
        test_saturate_pattern();
        test_stall_valid();
        test_backpressure();
        test_start_ignored();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
